// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron datapath. Neuron values (weights,
// partial sums, membrane potential) are 21-bit two's-complement
// fixed-point numbers.
//
// Contents:
//   DATA_W    - neuron data width in bits
//   MAX_DEPTH - deepest register chain the datapath registers support
//   data_t    - signed neuron data word
// ---------------------------------------------------------------------------
package neuron_pkg;

   localparam int DATA_W    = 21;
   localparam int MAX_DEPTH = 16;

   typedef logic signed [DATA_W-1:0] data_t;

endpackage : neuron_pkg

// File: rtl/dff1_stage.sv
// ---------------------------------------------------------------------------
// dff1_stage
// One WIDTH-bit signed register. It clears to zero when rst is high and
// captures d when en is high. Otherwise it holds its value. All state
// changes happen on the rising edge of clk.
//
// Ports:
//   d   in   WIDTH  data to capture (signed)
//   en  in   1      load enable
//   clk in   1      system clock
//   rst in   1      synchronous active-high reset
//   q   out  WIDTH  registered data (signed)
// ---------------------------------------------------------------------------
module dff1_stage
   import neuron_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic signed [WIDTH-1:0] d,
   input  logic                    en,
   input  logic                    clk,
   input  logic                    rst,
   output logic signed [WIDTH-1:0] q
);

   // Reset takes priority over the enable, so a reset edge always clears
   // the stage, even while a load is being requested. The copy is
   // bit-exact: no sign extension, truncation or saturation.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : dff1_stage

// File: rtl/dff1_reg.sv
// ---------------------------------------------------------------------------
// dff1_reg
// Signed data register with a load enable and a configurable pipeline
// depth. It holds neuron values between datapath stages. Each rising clk
// edge with set high moves the chain forward by one stage. Edges with set
// low leave every stage unchanged. A value therefore reaches out after
// DEPTH set-enabled edges.
//
// Parameters:
//   WIDTH  data width in bits (two's complement), defaults to DATA_W
//   DEPTH  number of register stages, 1..16
//
// Ports (positional order in, set, clk, out, rst; existing four-port
// hookups still line up, and rst is the appended fifth port):
//   in   in   WIDTH  data to capture (signed)
//   set  in   1      load enable, advances the chain
//   clk  in   1      system clock
//   out  out  WIDTH  data from the last stage (signed), driven by a flop
//   rst  in   1      synchronous active-high reset, clears every stage
// ---------------------------------------------------------------------------
module dff1_reg
   import neuron_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 1
) (
   input  logic signed [WIDTH-1:0] in,
   input  logic                    set,
   input  logic                    clk,
   output logic signed [WIDTH-1:0] out,
   input  logic                    rst
);

   logic signed [WIDTH-1:0] stage [DEPTH];

   // Build the chain from identical enabled flops. All stages share one
   // enable, so the whole chain advances together or holds together.
   // Stage 0 loads from the input port. Every later stage loads from the
   // stage before it.
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         dff1_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .d   (in),
            .en  (set),
            .clk (clk),
            .rst (rst),
            .q   (stage[g])
         );
      end else begin : g_tail
         dff1_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .d   (stage[g-1]),
            .en  (set),
            .clk (clk),
            .rst (rst),
            .q   (stage[g])
         );
      end
   end

   // The output is the last flop itself. No logic sits between the flop
   // and the port, so there is no combinational path from in or set to out.
   assign out = stage[DEPTH-1];

endmodule : dff1_reg

// File: tb/tb_dff1_reg.sv
// ---------------------------------------------------------------------------
// tb_dff1_reg
// Directed bench for dff1_reg. A single-stage instance and a three-stage
// instance share the same stimulus. Every expected value below is worked
// out by hand from the register's behaviour.
// ---------------------------------------------------------------------------
module tb_dff1_reg;

   localparam int W = 21;

   logic                clk;
   logic                rst;
   logic                set;
   logic signed [W-1:0] in;
   logic signed [W-1:0] out1;
   logic signed [W-1:0] out3;

   int checks = 0;
   int errors = 0;

   dff1_reg #(.WIDTH(W), .DEPTH(1)) dut1 (
      .in  (in),
      .set (set),
      .clk (clk),
      .out (out1),
      .rst (rst)
   );

   dff1_reg #(.WIDTH(W), .DEPTH(3)) dut3 (
      .in  (in),
      .set (set),
      .clk (clk),
      .out (out3),
      .rst (rst)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs. Then wait for the next rising edge and
   // settle 1 unit past it, so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic r, input logic s, input logic signed [W-1:0] d);
      rst = r;
      set = s;
      in  = d;
      @(posedge clk);
      #1;
   endtask

   // Compare both instances against their hand-computed expected values.
   task automatic checkOutput(input string tag, input logic signed [W-1:0] exp1,
                              input logic signed [W-1:0] exp3);
      checks++;
      assert (out1 === exp1) else begin
         errors++;
         $error("[TB] FAIL %s depth1 observed %h expected %h", tag, out1, exp1);
      end
      checks++;
      assert (out3 === exp3) else begin
         errors++;
         $error("[TB] FAIL %s depth3 observed %h expected %h", tag, out3, exp3);
      end
   endtask

   // Linear directed sequence. The comment before each step gives the
   // stage contents of the depth-3 chain (s0,s1,s2) after that edge.
   initial begin
      rst = 1'b0;
      set = 1'b0;
      in  = '0;
      @(negedge clk);

      // Reset wins over set: all stages are 0.
      applyStimulus(1'b1, 1'b1, 21'h047F0);
      checkOutput("reset_over_set", 21'sd0, 21'sd0);

      // Load 18416: (18416,0,0).
      applyStimulus(1'b0, 1'b1, 21'b000000100011111110000);
      checkOutput("load", 21'sd18416, 21'sd0);

      // Hold with in=-1 for three edges: nothing moves.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 21'h1FFFFF);
         checkOutput($sformatf("hold%0d", i), 21'sd18416, 21'sd0);
      end

      // Most negative value: (-1048576,18416,0).
      applyStimulus(1'b0, 1'b1, 21'h100000);
      checkOutput("negative", 21'h100000, 21'sd0);
      checks++;
      assert (out1 < 0) else begin
         errors++;
         $error("[TB] FAIL negative_sign observed %0d expected below 0", out1);
      end

      // Back-to-back loads 1,2,3: the old contents drain out of depth 3.
      applyStimulus(1'b0, 1'b1, 21'sd1);
      checkOutput("b2b_1", 21'sd1, 21'sd18416);
      applyStimulus(1'b0, 1'b1, 21'sd2);
      checkOutput("b2b_2", 21'sd2, 21'h100000);
      applyStimulus(1'b0, 1'b1, 21'sd3);
      checkOutput("b2b_3", 21'sd3, 21'sd1);

      // Mid-stream reset with the chain full (3,2,1) and set high.
      applyStimulus(1'b1, 1'b1, 21'sd7);
      checkOutput("midreset", 21'sd0, 21'sd0);

      // Refill: (1,0,0), then (2,1,0). A set-low edge does not count.
      // Then (3,2,1), so 1 comes out after the third set edge.
      applyStimulus(1'b0, 1'b1, 21'sd1);
      checkOutput("refill_1", 21'sd1, 21'sd0);
      applyStimulus(1'b0, 1'b1, 21'sd2);
      checkOutput("refill_2", 21'sd2, 21'sd0);
      applyStimulus(1'b0, 1'b0, 21'sd9);
      checkOutput("refill_hold", 21'sd2, 21'sd0);
      applyStimulus(1'b0, 1'b1, 21'sd3);
      checkOutput("refill_3", 21'sd3, 21'sd1);
      applyStimulus(1'b0, 1'b1, 21'sd4);
      checkOutput("refill_4", 21'sd4, 21'sd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dff1_reg
